xmpl_flt_ctrl: RTL and testbench

//  Issue side of the xmpl_flt filter core: buffers operand pairs from upstream, drives
//  en_flt/a7/b8 into the filter, waits for flt_status, and returns the 23-bit result

---
 rtl/xmpl_flt_ctrl_if.sv | 36 +++
 rtl/xmpl_flt_ctrl.sv | 159 +++++++++++++++
 tb/tb_xmpl_flt_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmpl_flt_ctrl_if.sv
// Operand, filter and result channels of the xmpl_flt issue controller.
//   op_*  : upstream operand pairs (valid/ready)
//   en_flt_o, flt_* : start pulse, operands and result/status of the filter
//   res_* : downstream result channel (valid/ready) with timeout error flag
// Modport slave is the controller side; master is the environment side.
interface xmpl_flt_ctrl_if;
   localparam int unsigned A_W = 7;
   localparam int unsigned B_W = 8;
   localparam int unsigned C_W = 23;

   logic           op_valid_i;
   logic           op_ready_o;
   logic [A_W-1:0] op_a7_i;
   logic [B_W-1:0] op_b8_i;

   logic           en_flt_o;
   logic [A_W-1:0] flt_a7_o;
   logic [B_W-1:0] flt_b8_o;
   logic [C_W-1:0] flt_c23_i;
   logic           flt_status_i;

   logic           res_valid_o;
   logic           res_ready_i;
   logic [C_W-1:0] res_c23_o;
   logic           res_err_o;

   modport slave (
      input  op_valid_i, op_a7_i, op_b8_i, flt_c23_i, flt_status_i, res_ready_i,
      output op_ready_o, en_flt_o, flt_a7_o, flt_b8_o, res_valid_o, res_c23_o, res_err_o
   );

   modport master (
      output op_valid_i, op_a7_i, op_b8_i, flt_c23_i, flt_status_i, res_ready_i,
      input  op_ready_o, en_flt_o, flt_a7_o, flt_b8_o, res_valid_o, res_c23_o, res_err_o
   );
endinterface

// File: rtl/xmpl_flt_ctrl.sv
// Issue side of the xmpl_flt filter core. Buffers operand pairs in a small FIFO,
// issues one request at a time to the filter (en_flt_o pulse + registered operands),
// waits for flt_status_i or a timeout, and presents the 23-bit result downstream.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   bus (slave)      : operand / filter / result channels (see xmpl_flt_ctrl_if)
//   busy_o           : controller not idle
//   fifo_level_o     : operand FIFO occupancy, 0..FIFO_DEPTH
//   tmo_cnt_o        : saturating timeout count, only with XMPL_FLT_CTRL_TMO_CNT_EN
// Optional feature macro: XMPL_FLT_CTRL_TMO_CNT_EN
module xmpl_flt_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   xmpl_flt_ctrl_if.slave                bus,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
   ,
   output logic [15:0]                   tmo_cnt_o
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned A_W   = 7;
   localparam int unsigned B_W   = 8;
   localparam int unsigned C_W   = 23;
   localparam int unsigned TMR_W = 16;
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

   state_t               state;
   logic [TMR_W-1:0]     timer;
   logic [A_W+B_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     fifo_level;

   logic                 en_flt;
   logic [A_W-1:0]       flt_a7;
   logic [B_W-1:0]       flt_b8;
   logic                 res_valid;
   logic [C_W-1:0]       res_c23;
   logic                 res_err;
   logic                 busy;

   logic                 op_ready_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 tmo_hit_c;

   // Ready depends on the registered level only; full blocks a push even when popping.
   assign op_ready_c = (fifo_level != LVL_FULL);
   assign push_c     = bus.op_valid_i && op_ready_c;
   assign pop_c      = (state == ST_IDLE) && (fifo_level != '0);
   // Status wins over timeout when both land in the same WAIT cycle.
   assign tmo_hit_c  = (state == ST_WAIT) && !bus.flt_status_i && (timer == TMO_LAST);

   // FIFO storage, no reset needed: contents are only read below the level.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         mem[wr_ptr] <= {bus.op_a7_i, bus.op_b8_i};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_level <= fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
      end
   end

   // Request FSM with registered outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= ST_IDLE;
         timer     <= '0;
         en_flt    <= 1'b0;
         flt_a7    <= '0;
         flt_b8    <= '0;
         res_valid <= 1'b0;
         res_c23   <= '0;
         res_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop_c) begin
                  {flt_a7, flt_b8} <= mem[rd_ptr];
                  en_flt           <= 1'b1;
                  busy             <= 1'b1;
                  state            <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               en_flt <= 1'b0;
               timer  <= '0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.flt_status_i) begin
                  res_c23   <= bus.flt_c23_i;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else if (tmo_hit_c) begin
                  res_c23   <= '0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_HOLD: begin
               if (bus.res_ready_i) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
   // Saturating count of aborted requests.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tmo_cnt_o <= '0;
      end else if (tmo_hit_c && (tmo_cnt_o != 16'hFFFF)) begin
         tmo_cnt_o <= tmo_cnt_o + 16'd1;
      end
   end
`endif

   assign bus.op_ready_o  = op_ready_c;
   assign bus.en_flt_o    = en_flt;
   assign bus.flt_a7_o    = flt_a7;
   assign bus.flt_b8_o    = flt_b8;
   assign bus.res_valid_o = res_valid;
   assign bus.res_c23_o   = res_c23;
   assign bus.res_err_o   = res_err;
   assign busy_o          = busy;
   assign fifo_level_o    = fifo_level;

endmodule

// File: tb/tb_xmpl_flt_ctrl.sv
// Directed bench for xmpl_flt_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_xmpl_flt_ctrl;
   localparam int unsigned FIFO_DEPTH     = 4;
   localparam int unsigned TIMEOUT_CYCLES = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [2:0] level;
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
   logic [15:0] tmo_cnt;
`endif

   int errors = 0;
   int checks = 0;

   xmpl_flt_ctrl_if bus ();

   xmpl_flt_ctrl #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (rst_n),
      .bus          (bus),
      .busy_o       (busy),
      .fifo_level_o (level)
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
      ,
      .tmo_cnt_o    (tmo_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [6:0] a, input logic [7:0] b);
      bus.op_valid_i = 1'b1;
      bus.op_a7_i    = a;
      bus.op_b8_i    = b;
      tick();
      bus.op_valid_i = 1'b0;
   endtask

   // Returns at the falling edge of the ISSUE cycle.
   task automatic wait_en(input string tag, input logic [6:0] a, input logic [7:0] b);
      int n = 0;
      while (bus.en_flt_o !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_en"}, 32'(bus.en_flt_o), 32'd1);
      chk({tag, "_a7"}, 32'(bus.flt_a7_o), 32'(a));
      chk({tag, "_b8"}, 32'(bus.flt_b8_o), 32'(b));
   endtask

   // Answers the filter request; in_issue=1 also shows a status strobe in ISSUE being ignored.
   task automatic respond(input string tag, input bit in_issue, input logic [22:0] d);
      if (in_issue) begin
         bus.flt_status_i = 1'b1;
         bus.flt_c23_i    = 23'h7FFFFF;
         tick();
         chk({tag, "_issue_drop"}, 32'(bus.res_valid_o), 32'd0);
      end
      bus.flt_status_i = 1'b1;
      bus.flt_c23_i    = d;
      tick();
      bus.flt_status_i = 1'b0;
      chk({tag, "_valid"}, 32'(bus.res_valid_o), 32'd1);
      chk({tag, "_c23"},   32'(bus.res_c23_o),   32'(d));
      chk({tag, "_err"},   32'(bus.res_err_o),   32'd0);
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      chk({tag, "_taken"}, 32'(bus.res_valid_o), 32'd0);
   endtask

   initial begin
      bit en_seen;
      bit stable;
      bit valid_seen;

      bus.op_valid_i   = 1'b0;
      bus.op_a7_i      = '0;
      bus.op_b8_i      = '0;
      bus.flt_c23_i    = '0;
      bus.flt_status_i = 1'b0;
      bus.res_ready_i  = 1'b0;

      // Reset values
      tick(2);
      chk("rst_op_ready", 32'(bus.op_ready_o),  32'd1);
      chk("rst_en",       32'(bus.en_flt_o),    32'd0);
      chk("rst_valid",    32'(bus.res_valid_o), 32'd0);
      chk("rst_c23",      32'(bus.res_c23_o),   32'd0);
      chk("rst_busy",     32'(busy),            32'd0);
      chk("rst_level",    32'(level),           32'd0);
      rst_n = 1'b1;
      tick();

      // Single request, status 3 cycles after the start pulse
      push(7'h12, 8'h34);
      chk("a_level1", 32'(level), 32'd1);
      chk("a_en_n1",  32'(bus.en_flt_o), 32'd0);
      tick();
      chk("a_en",    32'(bus.en_flt_o), 32'd1);
      chk("a_a7",    32'(bus.flt_a7_o), 32'h12);
      chk("a_b8",    32'(bus.flt_b8_o), 32'h34);
      chk("a_busy",  32'(busy),         32'd1);
      chk("a_level0",32'(level),        32'd0);
      tick();
      chk("a_en_pulse", 32'(bus.en_flt_o), 32'd0);
      tick(2);
      bus.flt_status_i = 1'b1;
      bus.flt_c23_i    = 23'h05A5A5;
      tick();
      bus.flt_status_i = 1'b0;
      chk("a_valid", 32'(bus.res_valid_o), 32'd1);
      chk("a_c23",   32'(bus.res_c23_o),   32'h05A5A5);
      chk("a_err",   32'(bus.res_err_o),   32'd0);
      tick(2);
      chk("a_hold_valid", 32'(bus.res_valid_o), 32'd1);
      chk("a_hold_c23",   32'(bus.res_c23_o),   32'h05A5A5);
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      chk("a_done_valid", 32'(bus.res_valid_o), 32'd0);
      chk("a_done_busy",  32'(busy),            32'd0);

      // Five back-to-back pushes with the filter stalled
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("b_ready_before_full", 32'(bus.op_ready_o), 32'd1);
         push(7'(7'h10 + i), 8'(8'h80 + i));
      end
      chk("b_level_full", 32'(level),           32'd4);
      chk("b_ready_full", 32'(bus.op_ready_o),  32'd0);
      push(7'h6A, 8'h6B);
      chk("b_blocked_level", 32'(level), 32'd4);
      respond("b0", 1'b0, 23'h100000);
      for (int i = 1; i < 5; i++) begin
         wait_en($sformatf("b%0d", i), 7'(7'h10 + i), 8'(8'h80 + i));
         chk($sformatf("b%0d_level", i), 32'(level), 32'(4 - i));
         respond($sformatf("b%0d", i), 1'b1, 23'(23'h100000 + i));
      end
      chk("b_empty", 32'(level), 32'd0);

      // Filter never answers: abort 65 cycles after the start pulse
      push(7'h55, 8'hAA);
      wait_en("c", 7'h55, 8'hAA);
      tick(64);
      chk("c_valid_64", 32'(bus.res_valid_o), 32'd0);
      tick();
      chk("c_valid_65", 32'(bus.res_valid_o), 32'd1);
      chk("c_err",      32'(bus.res_err_o),   32'd1);
      chk("c_c23",      32'(bus.res_c23_o),   32'd0);
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
      chk("c_tmo_cnt",  32'(tmo_cnt),         32'd1);
`endif
      bus.flt_status_i = 1'b1;
      bus.flt_c23_i    = 23'h123456;
      tick();
      bus.flt_status_i = 1'b0;
      chk("c_late_c23", 32'(bus.res_c23_o), 32'd0);
      chk("c_late_err", 32'(bus.res_err_o), 32'd1);
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;

      // Status on the last WAIT cycle wins over the timeout
      push(7'h22, 8'h33);
      wait_en("d", 7'h22, 8'h33);
      tick(64);
      chk("d_valid_pre", 32'(bus.res_valid_o), 32'd0);
      bus.flt_status_i = 1'b1;
      bus.flt_c23_i    = 23'h3C3C3C;
      tick();
      bus.flt_status_i = 1'b0;
      chk("d_valid", 32'(bus.res_valid_o), 32'd1);
      chk("d_err",   32'(bus.res_err_o),   32'd0);
      chk("d_c23",   32'(bus.res_c23_o),   32'h3C3C3C);
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
      chk("d_tmo_cnt", 32'(tmo_cnt), 32'd1);
`endif

      // Downstream stalls 20 cycles: result holds, FIFO keeps filling
      en_seen = 1'b0;
      stable  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.op_valid_i = (i < 3);
         bus.op_a7_i    = 7'(7'h40 + i);
         bus.op_b8_i    = 8'(8'hC0 + i);
         tick();
         en_seen = en_seen | bus.en_flt_o;
         if (bus.res_c23_o !== 23'h3C3C3C || bus.res_valid_o !== 1'b1 || bus.res_err_o !== 1'b0)
            stable = 1'b0;
      end
      bus.op_valid_i = 1'b0;
      chk("e_no_en",  32'(en_seen), 32'd0);
      chk("e_stable", 32'(stable),  32'd1);
      chk("e_level",  32'(level),   32'd3);
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      wait_en("e", 7'h40, 8'hC0);
      chk("e_level_pop", 32'(level), 32'd2);

      // Reset in WAIT with three operand pairs queued
      push(7'h4F, 8'hCF);
      chk("f_level3", 32'(level), 32'd3);
      chk("f_busy",   32'(busy),  32'd1);
      rst_n = 1'b0;
      tick();
      chk("f_en",       32'(bus.en_flt_o),    32'd0);
      chk("f_a7",       32'(bus.flt_a7_o),    32'd0);
      chk("f_b8",       32'(bus.flt_b8_o),    32'd0);
      chk("f_valid",    32'(bus.res_valid_o), 32'd0);
      chk("f_c23",      32'(bus.res_c23_o),   32'd0);
      chk("f_err",      32'(bus.res_err_o),   32'd0);
      chk("f_busy0",    32'(busy),            32'd0);
      chk("f_level0",   32'(level),           32'd0);
      chk("f_op_ready", 32'(bus.op_ready_o),  32'd1);
`ifdef XMPL_FLT_CTRL_TMO_CNT_EN
      chk("f_tmo_cnt",  32'(tmo_cnt),         32'd0);
`endif
      rst_n = 1'b1;
      en_seen    = 1'b0;
      valid_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         en_seen    = en_seen | bus.en_flt_o;
         valid_seen = valid_seen | bus.res_valid_o;
      end
      chk("f_no_en",    32'(en_seen),    32'd0);
      chk("f_no_valid", 32'(valid_seen), 32'd0);

      // Normal operation after reset, extreme operand and result values
      push(7'h7F, 8'hFF);
      wait_en("g", 7'h7F, 8'hFF);
      respond("g", 1'b1, 23'h7FFFFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard bound on total run time
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
